// File: rtl/histogram_esitle_akis.sv
// Two-pass streaming histogram equaliser: count pixels, prefix-sum, divide into a LUT, remap.
// Optional HIST_OKU_EN keeps raw bins apart from the CDF and exposes them via hist_addr_i/hist_o.
module histogram_esitle_akis #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 76800,
  parameter int CNT_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [PIX_W-1:0] out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
`ifdef HIST_OKU_EN
  input  logic [PIX_W-1:0] hist_addr_i,
  output logic [CNT_W-1:0] hist_o,
`endif
  output logic             busy_o,
  output logic             son_o
);
  localparam int BINS  = 2**PIX_W;
  localparam int NUM_W = CNT_W + PIX_W;
  localparam int BIT_W = $clog2(NUM_W);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_HIST  = 3'd2;
  localparam logic [2:0] ST_CDF   = 3'd3;
  localparam logic [2:0] ST_LUT   = 3'd4;
  localparam logic [2:0] ST_MAP   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [CNT_W-1:0] N_PIX_C  = CNT_W'(N_PIX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PIX_W-1:0] IDX_LAST = PIX_W'(BINS - 1);
  localparam logic [NUM_W-1:0] SCALE    = NUM_W'(BINS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_W - 1);

  logic [2:0]       state_r;
  logic [PIX_W-1:0] idx_r;
  logic [CNT_W-1:0] in_cnt_r, out_cnt_r, acc_r, cdf_min_r;
  logic             min_found_r;
  logic [NUM_W-1:0] num_r, q_r;
  logic [CNT_W:0]   rem_r;
  logic [BIT_W-1:0] bit_r;
  logic             div_run_r;
  logic             hist_rdy_r, out_valid_r, busy_r, son_r;
  logic [PIX_W-1:0] out_r;

  logic [CNT_W-1:0] bin_mem [BINS];
  logic [PIX_W-1:0] lut_mem [BINS];
`ifdef HIST_OKU_EN
  logic [CNT_W-1:0] cdf_mem [BINS];
  logic [CNT_W-1:0] hist_r;
`endif

  logic [CNT_W-1:0] acc_nxt_s, cdf_rd_s, diff_s, den_s;
  logic             above_s, qbit_s, lut_we_s;
  logic [NUM_W-1:0] numer_s, q_nxt_s;
  logic [CNT_W:0]   rem_sh_s, rem_nxt_s;
  logic [PIX_W-1:0] lut_val_s;
  logic             map_s, in_open_s, hist_xfer_s, map_in_s, map_out_s;

  assign acc_nxt_s = acc_r + bin_mem[idx_r];
`ifdef HIST_OKU_EN
  assign cdf_rd_s  = cdf_mem[idx_r];
`else
  assign cdf_rd_s  = bin_mem[idx_r];
`endif
  assign above_s   = (cdf_rd_s >= cdf_min_r);
  assign diff_s    = above_s ? (cdf_rd_s - cdf_min_r) : {CNT_W{1'b0}};
  assign numer_s   = NUM_W'(diff_s) * SCALE;
  assign den_s     = N_PIX_C - cdf_min_r;
  // Restoring division step: remainder stays below den, so one guard bit suffices.
  assign rem_sh_s  = (rem_r << 1) | {{CNT_W{1'b0}}, num_r[NUM_W-1]};
  assign qbit_s    = (rem_sh_s >= {1'b0, den_s});
  assign rem_nxt_s = qbit_s ? (rem_sh_s - {1'b0, den_s}) : rem_sh_s;
  assign q_nxt_s   = (q_r << 1) | {{(NUM_W-1){1'b0}}, qbit_s};
  assign lut_we_s  = (state_r == ST_LUT) && div_run_r && (bit_r == BIT_LAST);

  assign map_s       = (state_r == ST_MAP);
  assign in_open_s   = (in_cnt_r != N_PIX_C);
  assign pix_ready_o = hist_rdy_r | (map_s & in_open_s & (out_ready_i | ~out_valid_r));
  assign hist_xfer_s = (state_r == ST_HIST) & hist_rdy_r & pix_valid_i;
  assign map_in_s    = map_s & pix_valid_i & pix_ready_o;
  assign map_out_s   = map_s & out_valid_r & out_ready_i;

  assign out_o       = out_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = busy_r;
  assign son_o       = son_r;

  // Final LUT entry from the finished quotient, with the flat-image and below-minimum cases.
  always_comb begin
    lut_val_s = {PIX_W{1'b0}};
    if (den_s == {CNT_W{1'b0}}) begin
      lut_val_s = idx_r;
    end else if (!above_s) begin
      lut_val_s = {PIX_W{1'b0}};
    end else if (q_nxt_s > SCALE) begin
      lut_val_s = IDX_LAST;
    end else begin
      lut_val_s = q_nxt_s[PIX_W-1:0];
    end
  end

  // Bin array: cleared, incremented in a single-cycle read-modify-write, then prefix-summed.
  always_ff @(posedge clk_i) begin
    if (state_r == ST_CLEAR) begin
      bin_mem[idx_r] <= {CNT_W{1'b0}};
    end else if (hist_xfer_s) begin
      bin_mem[pix_i] <= bin_mem[pix_i] + CNT_ONE;
`ifndef HIST_OKU_EN
    end else if (state_r == ST_CDF) begin
      bin_mem[idx_r] <= acc_nxt_s;
`endif
    end
  end

`ifdef HIST_OKU_EN
  // Separate CDF store so the raw bins survive for readback.
  always_ff @(posedge clk_i) begin
    if (state_r == ST_CDF) begin
      cdf_mem[idx_r] <= acc_nxt_s;
    end
  end

  // Registered raw-bin readback port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_r <= {CNT_W{1'b0}};
    end else begin
      hist_r <= bin_mem[hist_addr_i];
    end
  end
  assign hist_o = hist_r;
`endif

  // LUT storage written at the end of each per-bin division.
  always_ff @(posedge clk_i) begin
    if (lut_we_s) begin
      lut_mem[idx_r] <= lut_val_s;
    end
  end

  // Control FSM, counters, divider datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      idx_r       <= {PIX_W{1'b0}};
      in_cnt_r    <= {CNT_W{1'b0}};
      out_cnt_r   <= {CNT_W{1'b0}};
      acc_r       <= {CNT_W{1'b0}};
      cdf_min_r   <= {CNT_W{1'b0}};
      min_found_r <= 1'b0;
      num_r       <= {NUM_W{1'b0}};
      q_r         <= {NUM_W{1'b0}};
      rem_r       <= {(CNT_W+1){1'b0}};
      bit_r       <= {BIT_W{1'b0}};
      div_run_r   <= 1'b0;
      hist_rdy_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= {PIX_W{1'b0}};
      busy_r      <= 1'b0;
      son_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en_i) begin
            state_r <= ST_CLEAR;
            idx_r   <= {PIX_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          idx_r <= idx_r + PIX_W'(1);
          if (idx_r == IDX_LAST) begin
            state_r    <= ST_HIST;
            hist_rdy_r <= 1'b1;
            in_cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_HIST: begin
          if (hist_xfer_s) begin
            in_cnt_r <= in_cnt_r + CNT_ONE;
            if (in_cnt_r == N_PIX_C - CNT_ONE) begin
              state_r     <= ST_CDF;
              hist_rdy_r  <= 1'b0;
              acc_r       <= {CNT_W{1'b0}};
              cdf_min_r   <= {CNT_W{1'b0}};
              min_found_r <= 1'b0;
            end
          end
        end
        ST_CDF: begin
          acc_r <= acc_nxt_s;
          idx_r <= idx_r + PIX_W'(1);
          if (!min_found_r && (acc_nxt_s != {CNT_W{1'b0}})) begin
            cdf_min_r   <= acc_nxt_s;
            min_found_r <= 1'b1;
          end
          if (idx_r == IDX_LAST) begin
            state_r   <= ST_LUT;
            div_run_r <= 1'b0;
          end
        end
        ST_LUT: begin
          if (!div_run_r) begin
            num_r     <= numer_s;
            rem_r     <= {(CNT_W+1){1'b0}};
            q_r       <= {NUM_W{1'b0}};
            bit_r     <= {BIT_W{1'b0}};
            div_run_r <= 1'b1;
          end else begin
            num_r <= num_r << 1;
            rem_r <= rem_nxt_s;
            q_r   <= q_nxt_s;
            bit_r <= bit_r + BIT_W'(1);
            if (bit_r == BIT_LAST) begin
              div_run_r <= 1'b0;
              idx_r     <= idx_r + PIX_W'(1);
              if (idx_r == IDX_LAST) begin
                state_r   <= ST_MAP;
                in_cnt_r  <= {CNT_W{1'b0}};
                out_cnt_r <= {CNT_W{1'b0}};
              end
            end
          end
        end
        ST_MAP: begin
          if (map_in_s) begin
            out_r       <= lut_mem[pix_i];
            out_valid_r <= 1'b1;
            in_cnt_r    <= in_cnt_r + CNT_ONE;
          end else if (map_out_s) begin
            out_valid_r <= 1'b0;
          end
          if (map_out_s) begin
            out_cnt_r <= out_cnt_r + CNT_ONE;
            if (out_cnt_r == N_PIX_C - CNT_ONE) begin
              state_r     <= ST_DONE;
              son_r       <= 1'b1;
              out_valid_r <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          son_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_histogram_esitle_akis.sv
// Randomised self-checking bench for histogram_esitle_akis against an arithmetic reference model.
module tb_histogram_esitle_akis;
  localparam int PIX_W = 4;
  localparam int N_PIX = 16;
  localparam int CNT_W = 5;
  localparam int BINS  = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni, en_i, pix_valid_i, out_ready_i;
  logic [PIX_W-1:0] pix_i;
  logic             pix_ready_o, out_valid_o, busy_o, son_o;
  logic [PIX_W-1:0] out_o;
`ifdef HIST_OKU_EN
  logic [PIX_W-1:0] hist_addr_i;
  logic [CNT_W-1:0] hist_o;
`endif

  int checks = 0;
  int errors = 0;
  int img [N_PIX];
  int h_exp [BINS];
  int exp_q [$];

  always #5 clk_i = ~clk_i;

  histogram_esitle_akis #(.PIX_W(PIX_W), .N_PIX(N_PIX), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .out_o(out_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
`ifdef HIST_OKU_EN
    .hist_addr_i(hist_addr_i), .hist_o(hist_o),
`endif
    .busy_o(busy_o), .son_o(son_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: histogram, cumulative counts, first nonzero cumulative, scaled LUT.
  task automatic build_model();
    int cdf [BINS];
    int lut [BINS];
    int acc, cmin, den;
    acc = 0; cmin = 0;
    foreach (h_exp[i]) h_exp[i] = 0;
    foreach (img[p]) h_exp[img[p]]++;
    for (int i = 0; i < BINS; i++) begin
      acc += h_exp[i];
      cdf[i] = acc;
      if (cmin == 0 && acc != 0) cmin = acc;
    end
    den = N_PIX - cmin;
    for (int i = 0; i < BINS; i++) begin
      if (den == 0) lut[i] = i;
      else if (cdf[i] < cmin) lut[i] = 0;
      else lut[i] = ((cdf[i] - cmin) * (BINS - 1)) / den;
      if (lut[i] > BINS - 1) lut[i] = BINS - 1;
    end
    exp_q.delete();
    foreach (img[p]) exp_q.push_back(lut[img[p]]);
  endtask

  task automatic run_image(input int gap_pct, input int stall_pct, input int abort_after);
    int p, n_out;
    logic prev_stall;
    logic [PIX_W-1:0] prev_out;
    build_model();
    @(negedge clk_i); en_i = 1'b1;
    @(negedge clk_i); en_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    // pass 1
    p = 0;
    for (int c = 0; c < 600 && p < N_PIX; c++) begin
      @(negedge clk_i);
      out_ready_i = 1'b1;
      if ($urandom_range(99) >= gap_pct) begin pix_valid_i = 1'b1; pix_i = img[p][PIX_W-1:0]; end
      else begin pix_valid_i = 1'b0; pix_i = PIX_W'($urandom); end
      #1;
      if (pix_valid_i && pix_ready_o) p++;
    end
    check("hist_inputs_taken", p, N_PIX);
    @(negedge clk_i);
    pix_valid_i = 1'b0;
    check("hist_ready_drop", pix_ready_o, 0);
    // CDF/LUT build: junk valid and en_i must be ignored
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i); #1;
      if (pix_ready_o) break;
      pix_valid_i = $urandom_range(1); pix_i = PIX_W'($urandom); en_i = $urandom_range(1);
    end
    pix_valid_i = 1'b0; en_i = 1'b0;
    check("map_ready_seen", pix_ready_o, 1);
    // pass 2
    p = 0; n_out = 0; prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk_i);
      if (prev_stall) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_data", out_o, prev_out);
      end
      out_ready_i = ($urandom_range(99) >= stall_pct);
      if (p < N_PIX && $urandom_range(99) >= gap_pct) begin pix_valid_i = 1'b1; pix_i = img[p][PIX_W-1:0]; end
      else begin pix_valid_i = 1'b0; pix_i = PIX_W'($urandom); end
      #1;
      if (out_valid_o && !out_ready_i) check("stall_ready_low", pix_ready_o, 0);
      if (pix_valid_i && pix_ready_o) p++;
      if (out_valid_o && out_ready_i) begin
        check("out_data", out_o, exp_q.pop_front());
        n_out++;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_out = out_o;
      if (n_out == N_PIX || (abort_after > 0 && n_out == abort_after)) break;
    end
    pix_valid_i = 1'b0;
    if (abort_after > 0) begin
      check("abort_reached", n_out, abort_after);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("abort_busy", busy_o, 0);
      check("abort_out_valid", out_valid_o, 0);
      check("abort_out", out_o, 0);
      check("abort_ready", pix_ready_o, 0);
      check("abort_son", son_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
    end else begin
      check("map_outputs_taken", n_out, N_PIX);
      @(negedge clk_i);
      check("son_pulse", son_o, 1);
      check("done_out_valid", out_valid_o, 0);
      check("done_busy", busy_o, 1);
      @(negedge clk_i);
      check("son_end", son_o, 0);
      check("idle_busy", busy_o, 0);
`ifdef HIST_OKU_EN
      for (int i = 0; i < BINS; i++) begin
        hist_addr_i = PIX_W'(i);
        @(negedge clk_i);
        check("hist_bin", hist_o, h_exp[i]);
      end
`endif
    end
  endtask

  initial begin
    rst_ni = 1'b1; en_i = 1'b0; pix_valid_i = 1'b0; out_ready_i = 1'b1; pix_i = '0;
`ifdef HIST_OKU_EN
    hist_addr_i = '0;
`endif
    #2 rst_ni = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out", out_o, 0);
    check("rst_ready", pix_ready_o, 0);
    check("rst_son", son_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    pix_valid_i = 1'b1;
    #1;
    check("idle_ready_low", pix_ready_o, 0);
    pix_valid_i = 1'b0;

    // flat image -> identity LUT
    foreach (img[p]) img[p] = 5;
    run_image(0, 0, 0);
    // ramp
    foreach (img[p]) img[p] = p;
    run_image(0, 0, 0);
    // two levels, then with random stalls
    foreach (img[p]) img[p] = (p < 8) ? 2 : 10;
    run_image(0, 0, 0);
    run_image(0, 50, 0);
    // back-to-back equal pixels, then gapped equal pixels
    foreach (img[p]) img[p] = 7;
    run_image(0, 0, 0);
    foreach (img[p]) img[p] = 3;
    run_image(40, 0, 0);
    // reset mid-MAP, then rerun the ramp
    foreach (img[p]) img[p] = p;
    run_image(0, 0, 5);
    run_image(0, 0, 0);
    // random images with random gaps and stalls
    for (int t = 0; t < 6; t++) begin
      int lo, hi;
      lo = $urandom_range(BINS - 1);
      hi = $urandom_range(BINS - 1, lo);
      foreach (img[p]) img[p] = $urandom_range(hi, lo);
      run_image($urandom_range(50), $urandom_range(60), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
